// File: rtl/mat_cop_seq.sv
// Multi-cycle coprocessor sequencer: iterative unsigned MUL / DIV / REM behind
// the controller's working / result_valid / error stall handshake.
module mat_cop_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              hold,
    input  logic              flush,
    output logic              working,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic              error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_REM = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          op_q;
    logic [DATA_W-1:0]   opnd_q;
    logic [2*DATA_W-1:0] acc;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_sh;
    logic [DATA_W:0]     div_diff;
    logic [2*DATA_W-1:0] acc_nxt;
    logic                bad_cmd;

    // acc is shared: MUL keeps {product_hi, multiplier}, DIV/REM keeps
    // {partial remainder, dividend shifting out / quotient shifting in}.
    always_comb begin
        mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
        div_sh   = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        acc_nxt  = acc;
        if (op_q == OP_MUL) begin
            if (acc[0])
                acc_nxt = {mul_sum, acc[DATA_W-1:1]};
            else
                acc_nxt = {1'b0, acc[2*DATA_W-1:1]};
        end else if (!div_diff[DATA_W]) begin
            acc_nxt = {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
        end else begin
            acc_nxt = {div_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
        end
    end

    assign bad_cmd = (op == OP_RSV) ||
                     (((op == OP_DIV) || (op == OP_REM)) && (src_b == '0));

    // Combinational accept term lets the controller stall in the command's own cycle.
    assign working      = (state != S_IDLE) || (start && !flush);
    assign result_valid = (state == S_DONE) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= OP_MUL;
            opnd_q <= '0;
            acc    <= '0;
            result <= '0;
            error  <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        opnd_q <= (op == OP_MUL) ? src_a : src_b;
                        acc    <= {{DATA_W{1'b0}}, (op == OP_MUL) ? src_b : src_a};
                        cnt    <= '0;
                        if (bad_cmd) begin
                            state  <= S_DONE;
                            result <= '0;
                            error  <= 1'b1;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_DONE;
                        case (op_q)
                            OP_MUL: begin
                                result <= acc_nxt[DATA_W-1:0];
                                error  <= |acc_nxt[2*DATA_W-1:DATA_W];
                            end
                            OP_REM: begin
                                result <= acc_nxt[2*DATA_W-1:DATA_W];
                                error  <= 1'b0;
                            end
                            default: begin
                                result <= acc_nxt[DATA_W-1:0];
                                error  <= 1'b0;
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    if (!hold)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_cop_seq.sv
// Directed bench for mat_cop_seq: latency, results, error cases, hold, reset and flush.
module tb_mat_cop_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, hold, flush;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         working, result_valid, error;
    logic [W-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    mat_cop_seq #(.DATA_W(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hold(hold), .flush(flush), .working(working), .result_valid(result_valid),
        .result(result), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic go(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op = o; src_a = a; src_b = b; start = 1'b1;
    endtask

    // Counts negedges until result_valid (bounded); lat=-1 if it never comes.
    task automatic wait_valid(output int lat, output bit work_ok);
        lat = -1; work_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!working) work_ok = 1'b0;
            if (result_valid) begin lat = i; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 0; hold = 0; flush = 0; op = 0; src_a = 0; src_b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (result_valid !== 1'b0 || result !== '0 || error !== 1'b0 || working !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rv=%b result=%h err=%b working=%b, want 0/0/0/0",
                     result_valid, result, error, working);
        end
        start = 1; #1;
        n_tests++;
        if (working !== 1'b1) begin
            n_fail++; $display("FAIL reset_comb_working: got %b want 1", working);
        end
        @(negedge clk); start = 0; rst = 0;
        @(negedge clk);
        n_tests++;
        if (working !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_idle: working=%b rv=%b want 0/0", working, result_valid);
        end
    endtask

    task automatic test_mul();
        int lat; bit wok;
        @(negedge clk); go(2'b00, 32'd7, 32'd6); #1;
        n_tests++;
        if (working !== 1'b1) begin n_fail++; $display("FAIL mul_working_T: got %b want 1", working); end
        wait_valid(lat, wok);
        n_tests++;
        if (lat != 33 || !wok) begin n_fail++; $display("FAIL mul_latency: lat=%0d working_held=%0b want 33/1", lat, wok); end
        n_tests++;
        if (result !== 32'd42 || error !== 1'b0) begin
            n_fail++; $display("FAIL mul_7x6: result=%0d err=%b want 42/0", result, error);
        end
        start = 0;
        @(negedge clk);
        n_tests++;
        if (working !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL mul_idle_after: working=%b rv=%b want 0/0", working, result_valid);
        end
    endtask

    task automatic test_mul_overflow();
        int lat; bit wok;
        @(negedge clk); go(2'b00, 32'h0001_0000, 32'h0001_0000);
        wait_valid(lat, wok);
        n_tests++;
        if (lat != 33 || result !== 32'h0 || error !== 1'b1) begin
            n_fail++; $display("FAIL mul_overflow: lat=%0d result=%h err=%b want 33/0/1", lat, result, error);
        end
        start = 0;
        @(negedge clk); go(2'b00, 32'hFFFF_FFFF, 32'd1);
        wait_valid(lat, wok);
        n_tests++;
        if (lat != 33 || result !== 32'hFFFF_FFFF || error !== 1'b0) begin
            n_fail++; $display("FAIL mul_max_by_one: lat=%0d result=%h err=%b want 33/ffffffff/0", lat, result, error);
        end
        start = 0;
    endtask

    task automatic test_back_to_back();
        int lat; bit wok;
        @(negedge clk); go(2'b01, 32'd100, 32'd7);
        wait_valid(lat, wok);
        n_tests++;
        if (lat != 33 || result !== 32'd14 || error !== 1'b0) begin
            n_fail++; $display("FAIL div_100_7: lat=%0d result=%0d err=%b want 33/14/0", lat, result, error);
        end
        op = 2'b10;
        @(negedge clk);
        n_tests++;
        if (working !== 1'b1 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: working=%b rv=%b want 1/0", working, result_valid);
        end
        wait_valid(lat, wok);
        n_tests++;
        if (lat != 33 || !wok || result !== 32'd2 || error !== 1'b0) begin
            n_fail++; $display("FAIL rem_100_7: lat=%0d wok=%0b result=%0d err=%b want 33/1/2/0", lat, wok, result, error);
        end
        start = 0;
        @(negedge clk);
    endtask

    task automatic test_div_edges();
        int lat; bit wok;
        @(negedge clk); go(2'b01, 32'hFFFF_FFFF, 32'd1);
        wait_valid(lat, wok); start = 0;
        n_tests++;
        if (lat != 33 || result !== 32'hFFFF_FFFF || error !== 1'b0) begin
            n_fail++; $display("FAIL div_max_by_one: lat=%0d result=%h err=%b want 33/ffffffff/0", lat, result, error);
        end
        @(negedge clk); go(2'b10, 32'hFFFF_FFFF, 32'd16);
        wait_valid(lat, wok); start = 0;
        n_tests++;
        if (lat != 33 || result !== 32'hF || error !== 1'b0) begin
            n_fail++; $display("FAIL rem_max_by_16: lat=%0d result=%h err=%b want 33/f/0", lat, result, error);
        end
        @(negedge clk); go(2'b01, 32'd5, 32'd7);
        wait_valid(lat, wok); start = 0;
        n_tests++;
        if (lat != 33 || result !== 32'd0 || error !== 1'b0) begin
            n_fail++; $display("FAIL div_small: lat=%0d result=%0d err=%b want 33/0/0", lat, result, error);
        end
    endtask

    task automatic test_errors();
        int lat; bit wok;
        @(negedge clk); go(2'b01, 32'd5, 32'd0); #1;
        n_tests++;
        if (working !== 1'b1) begin n_fail++; $display("FAIL div0_working_T: got %b want 1", working); end
        wait_valid(lat, wok);
        n_tests++;
        if (lat != 1 || result !== 32'd0 || error !== 1'b1) begin
            n_fail++; $display("FAIL div_by_zero: lat=%0d result=%h err=%b want 1/0/1", lat, result, error);
        end
        start = 0;
        @(negedge clk);
        n_tests++;
        if (working !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL div0_release: working=%b rv=%b want 0/0", working, result_valid);
        end
        // Leave a nonzero result behind so the illegal op must clear it.
        go(2'b00, 32'd3, 32'd3);
        wait_valid(lat, wok); start = 0;
        @(negedge clk); go(2'b11, 32'd9, 32'd3);
        wait_valid(lat, wok);
        n_tests++;
        if (lat != 1 || !wok || result !== 32'd0 || error !== 1'b1) begin
            n_fail++; $display("FAIL illegal_op: lat=%0d wok=%0b result=%h err=%b want 1/1/0/1", lat, wok, result, error);
        end
        start = 0;
        @(negedge clk);
        n_tests++;
        if (working !== 1'b0) begin n_fail++; $display("FAIL illegal_release: working=%b want 0", working); end
    endtask

    task automatic test_hold();
        int lat; bit wok; int bad;
        @(negedge clk); go(2'b00, 32'd12345, 32'd3);
        repeat (5) @(negedge clk);
        hold = 1;
        wait_valid(lat, wok);
        n_tests++;
        if (lat != 28 || result !== 32'd37035 || error !== 1'b0) begin
            n_fail++; $display("FAIL hold_result: lat=%0d result=%0d err=%b want 28/37035/0", lat, result, error);
        end
        start = 0; bad = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (result_valid !== 1'b1 || result !== 32'd37035) bad++;
            if (i == 5) hold = 0;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL hold_stays_done: bad_cycles=%0d want 0", bad); end
        @(negedge clk);
        n_tests++;
        if (result_valid !== 1'b0 || working !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: rv=%b working=%b want 0/0", result_valid, working);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(negedge clk); go(2'b00, 32'd7, 32'd6);
        repeat (10) @(negedge clk);
        rst = 1; start = 0;
        @(negedge clk);
        n_tests++;
        if (working !== 1'b0 || result_valid !== 1'b0 || result !== '0) begin
            n_fail++; $display("FAIL reset_mid: working=%b rv=%b result=%h want 0/0/0", working, result_valid, result);
        end
        rst = 0; seen = 0;
        repeat (40) begin @(negedge clk); if (result_valid) seen = 1; end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL reset_mid_no_result: result_valid seen=%0b want 0", seen); end
    endtask

    task automatic test_flush();
        int lat; bit wok; bit seen;
        @(negedge clk); go(2'b00, 32'd7, 32'd6);
        wait_valid(lat, wok); start = 0;
        @(negedge clk); go(2'b00, 32'd5, 32'd5);
        repeat (10) @(negedge clk);
        flush = 1; start = 0;
        @(negedge clk);
        n_tests++;
        if (working !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: working=%b rv=%b want 0/0", working, result_valid);
        end
        flush = 0; seen = 0;
        repeat (40) begin @(negedge clk); if (result_valid) seen = 1; end
        n_tests++;
        if (seen || result !== 32'd42 || error !== 1'b0) begin
            n_fail++; $display("FAIL flush_keeps_result: rv_seen=%0b result=%0d err=%b want 0/42/0", seen, result, error);
        end
        go(2'b00, 32'd2, 32'd2); flush = 1; #1;
        n_tests++;
        if (working !== 1'b0) begin n_fail++; $display("FAIL flush_start_working: got %b want 0", working); end
        @(negedge clk); start = 0; flush = 0; #1;
        n_tests++;
        if (working !== 1'b0) begin n_fail++; $display("FAIL flush_start_not_accepted: working=%b want 0", working); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mul_overflow();
        test_back_to_back();
        test_div_edges();
        test_errors();
        test_hold();
        test_reset_mid();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
